// File: rtl/dm_lsu.sv
// Data-memory load/store unit: loads complete 2 cycles after accept, SW in 2, SH/SB in 3 (read-modify-write).
// One request in flight; req_ready only in IDLE. LSU_ALIGN_CHECK_EN turns misalignment into an err pulse instead of truncation.
module dm_lsu (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic [31:0] A,
    output logic [31:0] WD,
    output logic        RE,
    output logic        WE,
    output logic [31:0] PC,
    input  logic [31:0] RD
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STORE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_done;

    logic        w_accept;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_bad;
    logic [31:0] w_addr_in;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merge_in;

    assign req_ready = (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_is_word = (req_op == OP_LW) || (req_op == OP_SW);
    assign w_is_half = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);

`ifdef LSU_ALIGN_CHECK_EN
    logic r_err;

    assign w_bad     = (w_is_word && (req_addr[1:0] != 2'b00)) || (w_is_half && req_addr[0]);
    assign w_addr_in = req_addr;
    assign err       = r_err;

    // A rejected request never leaves IDLE; err is the only trace it leaves.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && w_bad;
        end
    end
`else
    assign w_bad     = 1'b0;
    assign w_addr_in = {req_addr[31:2],
                        req_addr[1] & ~w_is_word,
                        req_addr[0] & ~(w_is_word | w_is_half)};
    assign err       = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_bad) begin
                    case (req_op)
                        OP_SW:        w_state_nxt = S_STORE;
                        OP_SH, OP_SB: w_state_nxt = S_RMW_RD;
                        default:      w_state_nxt = S_LOAD;
                    endcase
                end
            end
            S_LOAD:   w_state_nxt = S_IDLE;
            S_STORE:  w_state_nxt = S_IDLE;
            S_RMW_RD: w_state_nxt = S_RMW_WR;
            S_RMW_WR: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Little-endian lane selection on the latched address.
    always_comb begin
        w_byte = RD[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = RD[7:0];
            2'd1: w_byte = RD[15:8];
            2'd2: w_byte = RD[23:16];
            2'd3: w_byte = RD[31:24];
            default: w_byte = RD[7:0];
        endcase
        w_half = r_addr[1] ? RD[31:16] : RD[15:0];
        case (r_op)
            OP_LH:   w_load_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_ext = {16'h0000, w_half};
            OP_LB:   w_load_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_ext = {24'h000000, w_byte};
            default: w_load_ext = RD;
        endcase
    end

    always_comb begin
        w_merge_in = RD;
        if (r_op == OP_SB) begin
            case (r_addr[1:0])
                2'd0: w_merge_in[7:0]   = r_wdata[7:0];
                2'd1: w_merge_in[15:8]  = r_wdata[7:0];
                2'd2: w_merge_in[23:16] = r_wdata[7:0];
                2'd3: w_merge_in[31:24] = r_wdata[7:0];
                default: w_merge_in = RD;
            endcase
        end else if (r_addr[1]) begin
            w_merge_in[31:16] = r_wdata[15:0];
        end else begin
            w_merge_in[15:0] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_op     <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_pc     <= 32'h0;
            r_merge  <= 32'h0;
            r_rdata  <= 32'h0;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= (r_state == S_LOAD);
            r_done   <= (r_state == S_STORE) || (r_state == S_RMW_WR);
            if (w_accept) begin
                r_op    <= req_op;
                r_addr  <= w_addr_in;
                r_wdata <= req_wdata;
                r_pc    <= req_pc;
            end
            if (r_state == S_LOAD) begin
                r_rdata <= w_load_ext;
            end
            if (r_state == S_RMW_RD) begin
                r_merge <= w_merge_in;
            end
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign done   = r_done;
    assign A      = r_addr;
    assign PC     = r_pc;
    assign RE     = (r_state == S_LOAD) || (r_state == S_RMW_RD);
    assign WE     = (r_state == S_STORE) || (r_state == S_RMW_WR);
    assign WD     = (r_state == S_RMW_WR) ? r_merge : r_wdata;

endmodule
